user_io_mmio: RTL and testbench
===============================

// Module: user_io_mmio
// PURPOSE
// - Memory-mapped responder for the Riscv151 user I/O: CPU loads/stores hit this block; it owns the LED register,
//   samples switches and converts clean_buttons rising edges into queued press events.
// - Sits in the CPU's IO address decode, in parallel with the UART MMIO; drives top-level leds directly.
// PARAMETERS
// - N_BUTTONS   3   width of clean_buttons / button event word
// - N_SWITCHES  2   width of switches
// - N_LEDS      6   width of leds
// - FIFO_DEPTH  8   button event queue depth (power of 2, >=2)
// PORTS
// - clk            in   1           CPU clock
// - rst            in   1           synchronous, active-high reset
// - io_addr        in   8           byte offset within user-IO window (bits [1:0] ignored)
// - io_ren         in   1           load request this cycle
// - io_wen         in   1           store request this cycle (full 32-bit word)
// - io_wdata       in   32          store data
// - io_rdata       out  32          load data, valid the cycle after io_ren
// - clean_buttons  in   N_BUTTONS   debounced, synchronised buttons (level)
// - switches       in   N_SWITCHES  raw slide switches (asynchronous)
// - leds           out  N_LEDS      LED drive
// BEHAVIOUR
// - Register map (offset, access):
//   0x00 LED      RW  [N_LEDS-1:0]=leds; other bits read 0.
//   0x04 SWITCH   RO  [N_SWITCHES-1:0]=switches after 2-flop synchroniser.
//   0x08 BSTATUS  RO  bit0=event available (!empty), bit1=overflow sticky, [7:4]=occupancy count (saturate display at 15).
//   0x0C BDATA    RO  [N_BUTTONS-1:0]=oldest event mask; load pops when non-empty; load when empty returns 0, no pop.
//   0x10 BCLEAR   WO  any store: flush queue, clear overflow. Reads 0.
//   Unmapped offsets: read 0, writes ignored. Writes to RO offsets ignored.
// - Reset (rst high at posedge): leds=0, io_rdata=0, queue empty, overflow=0, sync flops=0,
//   btn_prev<=clean_buttons (no spurious event for buttons held through reset); no push during reset.
// - Read latency: exactly 1 cycle; io_rdata registered, holds last value when io_ren=0.
//   Value returned = register state before the request edge (BDATA returns head entry, pop commits same edge).
// - Write: takes effect at the request edge; LED read in next cycle returns new value.
// - Event detect: rise = clean_buttons & ~btn_prev each cycle; if rise!=0 push rise (multi-bit mask if simultaneous).
// - Full queue push without pop: event dropped, overflow<=1. Full + push + pop same cycle: both occur, no overflow.
// - Empty + push + BDATA load same cycle: load returns 0, push lands, count=1.
// - BCLEAR store concurrent with push: clear wins, push discarded, overflow=0.
// - io_ren and io_wen same cycle: both honoured independently (read sees pre-write state).
// - Pointers log2(FIFO_DEPTH) bits, wrap naturally; count log2(FIFO_DEPTH)+1 bits.
// - rst mid-operation: queue flushed, pending read data lost (io_rdata=0 next cycle).
// STRUCTURE
// - user_io_defines.vh: localparam offsets (LED/SWITCH/BSTATUS/BDATA/BCLEAR), BSTATUS bit positions;
//   shared with software header generation and the testbench.
// - Sub-module button_event_fifo: sync FIFO (push, pop, flush, full, empty, count, dout=head, combinational);
//   top level holds decode, LED reg, switch sync, edge detect, read mux and overflow flag.
// TESTING
// - Store 0x2A to 0x00, load 0x00 -> io_rdata=0x2A next cycle, leds=6'b101010; store 0xFFFFFFFF -> reads 0x3F.
// - switches=2'b10 held 3 cycles, load 0x04 -> 0x2; change to 2'b01, load next cycle -> still 0x2 (sync lag).
// - Pulse buttons 3'b001 then 3'b110 (same cycle rise of bits 1,2) -> BSTATUS=0x21; BDATA loads 0x1, 0x6, 0x0.
// - 9 distinct presses, no pops (depth 8) -> BSTATUS=0x83; BCLEAR store -> BSTATUS=0x00.
// - Hold button 0 high through reset, release after -> no event (BSTATUS=0); full + push + BDATA pop same cycle -> count stays 8, overflow 0.

Source files
------------

// File: rtl/user_io_mmio_pkg.sv
// Shared register map and decode helpers for the user I/O MMIO window.
// Offsets and BSTATUS bit positions are the same ones software headers are generated from.
package user_io_mmio_pkg;

  localparam logic [7:0] OFF_LED     = 8'h00;
  localparam logic [7:0] OFF_SWITCH  = 8'h04;
  localparam logic [7:0] OFF_BSTATUS = 8'h08;
  localparam logic [7:0] OFF_BDATA   = 8'h0C;
  localparam logic [7:0] OFF_BCLEAR  = 8'h10;

  localparam int unsigned BSTAT_AVAIL_BIT = 0;
  localparam int unsigned BSTAT_OVF_BIT   = 1;
  localparam int unsigned BSTAT_CNT_LSB   = 4;
  localparam int unsigned BSTAT_CNT_MSB   = 7;

  typedef enum logic [2:0] {
    RegLed,
    RegSwitch,
    RegBstatus,
    RegBdata,
    RegBclear,
    RegNone
  } reg_sel_e;

  // Takes the word address only; byte-lane bits are not part of the decode.
  function automatic reg_sel_e decode_reg(input logic [5:0] word_addr);
    reg_sel_e sel;
    case ({word_addr, 2'b00})
      OFF_LED:     sel = RegLed;
      OFF_SWITCH:  sel = RegSwitch;
      OFF_BSTATUS: sel = RegBstatus;
      OFF_BDATA:   sel = RegBdata;
      OFF_BCLEAR:  sel = RegBclear;
      default:     sel = RegNone;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/user_io_mmio_if.sv
// CPU-side load/store port into the user I/O window.
interface user_io_mmio_if;
  logic [7:0]  io_addr;
  logic        io_ren;
  logic        io_wen;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;

  modport master (output io_addr, output io_ren, output io_wen, output io_wdata,
                  input io_rdata);
  modport slave  (input io_addr, input io_ren, input io_wen, input io_wdata,
                  output io_rdata);
endinterface

// File: rtl/user_io_mmio_button_event_fifo.sv
// Synchronous FIFO for button press events; dout shows the head entry combinationally.
module user_io_mmio_button_event_fifo #(
  parameter int unsigned Width = 3,
  parameter int unsigned Depth = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [Width-1:0]           din,
  output logic [Width-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(Depth):0]     count
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PtrW + 1)'(Depth));
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full queue can still accept.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/user_io_mmio.sv
// User I/O MMIO responder: LED register, synchronised switches and a queue of button press events.
module user_io_mmio
  import user_io_mmio_pkg::*;
#(
  parameter int unsigned N_BUTTONS  = 3,
  parameter int unsigned N_SWITCHES = 2,
  parameter int unsigned N_LEDS     = 6,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  user_io_mmio_if.slave         bus,
  input  logic [N_BUTTONS-1:0]  clean_buttons,
  input  logic [N_SWITCHES-1:0] switches,
  output logic [N_LEDS-1:0]     leds
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  reg_sel_e              sel;
  logic                  unused_addr_lsb;
  logic [N_LEDS-1:0]     led_q;
  logic [N_SWITCHES-1:0] sw_meta_q, sw_sync_q;
  logic [N_BUTTONS-1:0]  btn_prev_q, rise;
  logic                  ovf_q;
  logic [31:0]           rdata_d;

  logic                  fifo_push, fifo_pop, fifo_flush;
  logic                  fifo_full, fifo_empty;
  logic [N_BUTTONS-1:0]  fifo_dout;
  logic [CntW-1:0]       fifo_count;
  logic [31:0]           cnt_wide;
  logic [3:0]            cnt_disp;

  assign sel             = decode_reg(bus.io_addr[7:2]);
  assign unused_addr_lsb = ^bus.io_addr[1:0];

  assign rise       = clean_buttons & ~btn_prev_q;
  assign fifo_push  = ~rst & (|rise);
  assign fifo_pop   = bus.io_ren & (sel == RegBdata) & ~fifo_empty;
  assign fifo_flush = bus.io_wen & (sel == RegBclear);

  user_io_mmio_button_event_fifo #(
    .Width (N_BUTTONS),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (rise),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // btn_prev tracks the buttons even in reset so a button held through reset never fires.
  always_ff @(posedge clk) begin
    btn_prev_q <= clean_buttons;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      sw_meta_q <= switches;
      sw_sync_q <= sw_meta_q;
      if (bus.io_wen && sel == RegLed) led_q <= bus.io_wdata[N_LEDS-1:0];
      if (fifo_flush) begin
        ovf_q <= 1'b0;
      end else if (fifo_push && fifo_full && !fifo_pop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign cnt_wide = 32'(fifo_count);
  assign cnt_disp = (cnt_wide > 32'd15) ? 4'hF : cnt_wide[3:0];

  // Read mux sees pre-edge state; BDATA pop and any write commit at the same edge.
  always_comb begin
    rdata_d = '0;
    case (sel)
      RegLed:    rdata_d[N_LEDS-1:0] = led_q;
      RegSwitch: rdata_d[N_SWITCHES-1:0] = sw_sync_q;
      RegBstatus: begin
        rdata_d[BSTAT_AVAIL_BIT]             = ~fifo_empty;
        rdata_d[BSTAT_OVF_BIT]               = ovf_q;
        rdata_d[BSTAT_CNT_MSB:BSTAT_CNT_LSB] = cnt_disp;
      end
      RegBdata: begin
        if (!fifo_empty) rdata_d[N_BUTTONS-1:0] = fifo_dout;
      end
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.io_rdata <= '0;
    end else if (bus.io_ren) begin
      bus.io_rdata <= rdata_d;
    end
  end

  assign leds = led_q;

endmodule

// File: tb/tb_user_io_mmio.sv
// Directed self-checking bench for user_io_mmio with hand-computed expected values.
module tb_user_io_mmio;
  import user_io_mmio_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] clean_buttons;
  logic [1:0] switches;
  logic [5:0] leds;
  int         checks = 0;
  int         errors = 0;

  user_io_mmio_if bus ();

  user_io_mmio #(
    .N_BUTTONS  (3),
    .N_SWITCHES (2),
    .N_LEDS     (6),
    .FIFO_DEPTH (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .clean_buttons (clean_buttons),
    .switches      (switches),
    .leds          (leds)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic load(input logic [7:0] addr, input logic [31:0] exp, input string tag);
    @(negedge clk);
    bus.io_addr = addr;
    bus.io_ren  = 1'b1;
    @(posedge clk);
    #1;
    bus.io_ren = 1'b0;
    check(tag, bus.io_rdata, exp);
  endtask

  task automatic store(input logic [7:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.io_addr  = addr;
    bus.io_wdata = data;
    bus.io_wen   = 1'b1;
    @(posedge clk);
    #1;
    bus.io_wen = 1'b0;
  endtask

  task automatic press(input logic [2:0] mask);
    @(negedge clk);
    clean_buttons = mask;
    @(negedge clk);
    clean_buttons = 3'b000;
  endtask

  initial begin
    bus.io_addr   = '0;
    bus.io_ren    = 1'b0;
    bus.io_wen    = 1'b0;
    bus.io_wdata  = '0;
    rst           = 1'b1;
    clean_buttons = 3'b001;
    switches      = 2'b00;

    // Reset with button 0 held; releasing it afterwards must not queue anything.
    tick(3);
    #1;
    check("reset_leds", 32'(leds), 32'h0);
    check("reset_rdata", bus.io_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick(2);
    @(negedge clk);
    clean_buttons = 3'b000;
    load(OFF_BSTATUS, 32'h0, "held_btn_no_event");

    // LED register
    store(OFF_LED, 32'h2A);
    load(OFF_LED, 32'h2A, "led_read");
    check("led_pins", 32'(leds), 32'h2A);
    store(OFF_LED, 32'hFFFF_FFFF);
    load(OFF_LED, 32'h3F, "led_read_mask");

    // Unmapped and read-only offsets
    store(8'h14, 32'h0);
    store(OFF_SWITCH, 32'h0);
    check("ignored_writes", 32'(leds), 32'h3F);
    load(8'h20, 32'h0, "unmapped_read");
    load(OFF_BCLEAR, 32'h0, "bclear_read");

    // Switch synchroniser lag
    @(negedge clk);
    switches = 2'b10;
    tick(3);
    load(OFF_SWITCH, 32'h2, "switch_10");
    @(negedge clk);
    switches    = 2'b01;
    bus.io_addr = OFF_SWITCH;
    bus.io_ren  = 1'b1;
    @(posedge clk);
    #1;
    bus.io_ren = 1'b0;
    check("switch_lag", bus.io_rdata, 32'h2);
    tick(2);
    load(OFF_SWITCH, 32'h1, "switch_01");
    tick(3);
    #1;
    check("rdata_hold", bus.io_rdata, 32'h1);

    // Single and simultaneous presses
    press(3'b001);
    press(3'b110);
    load(OFF_BSTATUS, 32'h21, "bstatus_two");
    load(OFF_BDATA, 32'h1, "bdata_first");
    load(OFF_BDATA, 32'h6, "bdata_multi");
    load(OFF_BDATA, 32'h0, "bdata_empty");
    load(OFF_BSTATUS, 32'h0, "bstatus_drained");

    // Overflow then clear
    repeat (9) press(3'b001);
    load(OFF_BSTATUS, 32'h83, "bstatus_overflow");
    store(OFF_BCLEAR, 32'h0);
    load(OFF_BSTATUS, 32'h0, "bstatus_cleared");

    // Full queue, push and pop in the same cycle
    repeat (8) press(3'b001);
    load(OFF_BSTATUS, 32'h81, "bstatus_full");
    @(negedge clk);
    clean_buttons = 3'b010;
    bus.io_addr   = OFF_BDATA;
    bus.io_ren    = 1'b1;
    @(posedge clk);
    #1;
    bus.io_ren = 1'b0;
    check("full_push_pop_data", bus.io_rdata, 32'h1);
    @(negedge clk);
    clean_buttons = 3'b000;
    load(OFF_BSTATUS, 32'h81, "full_push_pop_stat");
    repeat (7) load(OFF_BDATA, 32'h1, "drain_full");
    load(OFF_BDATA, 32'h2, "wrapped_tail");
    load(OFF_BSTATUS, 32'h0, "drained_after_wrap");

    // Empty queue, push and BDATA load in the same cycle
    @(negedge clk);
    clean_buttons = 3'b100;
    bus.io_addr   = OFF_BDATA;
    bus.io_ren    = 1'b1;
    @(posedge clk);
    #1;
    bus.io_ren = 1'b0;
    check("empty_push_pop_data", bus.io_rdata, 32'h0);
    @(negedge clk);
    clean_buttons = 3'b000;
    load(OFF_BSTATUS, 32'h11, "empty_push_pop_stat");
    load(OFF_BDATA, 32'h4, "empty_push_pop_entry");

    // Clear concurrent with a push, starting from an overflowed queue
    repeat (9) press(3'b010);
    @(negedge clk);
    clean_buttons = 3'b001;
    bus.io_addr   = OFF_BCLEAR;
    bus.io_wen    = 1'b1;
    @(posedge clk);
    #1;
    bus.io_wen = 1'b0;
    @(negedge clk);
    clean_buttons = 3'b000;
    load(OFF_BSTATUS, 32'h0, "clear_beats_push");

    // Simultaneous load and store to LED
    @(negedge clk);
    bus.io_addr  = OFF_LED;
    bus.io_wdata = 32'h15;
    bus.io_wen   = 1'b1;
    bus.io_ren   = 1'b1;
    @(posedge clk);
    #1;
    bus.io_wen = 1'b0;
    bus.io_ren = 1'b0;
    check("rw_same_cycle_old", bus.io_rdata, 32'h3F);
    check("rw_same_cycle_pins", 32'(leds), 32'h15);
    load(OFF_LED, 32'h15, "rw_same_cycle_new");

    // Reset mid-operation drops the pending read and flushes the queue
    press(3'b010);
    @(negedge clk);
    bus.io_addr = OFF_LED;
    bus.io_ren  = 1'b1;
    rst         = 1'b1;
    @(posedge clk);
    #1;
    bus.io_ren = 1'b0;
    check("rst_rdata", bus.io_rdata, 32'h0);
    check("rst_leds", 32'(leds), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    load(OFF_BSTATUS, 32'h0, "rst_flushed");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
